// File: rtl/fp_mult_arbiter_if.sv
// fp_mult_arbiter_if: request, multiplier and response signals around the shared multiplier
interface fp_mult_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0] req_valid, req_ready, rsp_valid;
  logic [N_REQ*32-1:0] req_a, req_b;
  logic [N_REQ*3-1:0] req_rnd;
  logic [31:0] mult_a, mult_b, mult_z, rsp_z;
  logic [2:0] mult_rnd;
  logic [7:0] mult_status, rsp_status;
  logic busy, err_sticky;
  modport master (
    output req_valid, req_a, req_b, req_rnd, mult_z, mult_status,
    input req_ready, mult_a, mult_b, mult_rnd, rsp_valid, rsp_z, rsp_status, busy, err_sticky
  );
  modport slave (
    input req_valid, req_a, req_b, req_rnd, mult_z, mult_status,
    output req_ready, mult_a, mult_b, mult_rnd, rsp_valid, rsp_z, rsp_status, busy, err_sticky
  );
endinterface

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: round-robin sharing of one pipelined fp multiplier with tag-routed responses
module fp_mult_arbiter #(
  parameter int N_REQ = 4,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst,
  fp_mult_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] ptr_q, ptr_d, gnt_id, iss_id_q, last_id;
  logic gnt_any, iss_vld_q, err_q, last_v;
  logic [LATENCY-1:0] tv_q;
  logic [LATENCY*IW-1:0] tid_q;
  logic [31:0] a_q, b_q, z_q;
  logic [2:0] rnd_q;
  logic [7:0] st_q;
  logic [N_REQ-1:0] rv_q;
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = ptr_q;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (bus.req_valid[(int'(ptr_q) + k) % N_REQ]) begin
        gnt_any = 1'b1;
        gnt_id = IW'((int'(ptr_q) + k) % N_REQ);
      end
    ptr_d = gnt_id == IW'(N_REQ - 1) ? '0 : gnt_id + 1'b1;
  end
  assign last_v = tv_q[LATENCY-1];
  assign last_id = tid_q[LATENCY*IW-1 -: IW];
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      iss_vld_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      rnd_q <= '0;
      tv_q <= '0;
      rv_q <= '0;
      z_q <= '0;
      st_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= gnt_any ? ptr_d : ptr_q;
      iss_vld_q <= gnt_any;
      iss_id_q <= gnt_id;
      a_q <= gnt_any ? bus.req_a[32*int'(gnt_id) +: 32] : '0;
      b_q <= gnt_any ? bus.req_b[32*int'(gnt_id) +: 32] : '0;
      rnd_q <= gnt_any ? bus.req_rnd[3*int'(gnt_id) +: 3] : '0;
      tv_q <= LATENCY'({tv_q, iss_vld_q});
      tid_q <= (LATENCY*IW)'({tid_q, iss_id_q});
      rv_q <= last_v ? N_REQ'(1) << last_id : '0;
      if (last_v) begin
        z_q <= bus.mult_z;
        st_q <= bus.mult_status;
      end
      if (last_v && |bus.mult_status[7:6]) err_q <= 1'b1;
    end
  end
  assign bus.req_ready = gnt_any ? N_REQ'(1) << gnt_id : '0;
  assign bus.mult_a = a_q;
  assign bus.mult_b = b_q;
  assign bus.mult_rnd = rnd_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_z = z_q;
  assign bus.rsp_status = st_q;
  assign bus.busy = iss_vld_q | |tv_q;
  assign bus.err_sticky = err_q;
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb_fp_mult_arbiter: randomized and directed scoreboard bench with a stub multiplier
module tb_fp_mult_arbiter;
  localparam int N = 4;
  localparam int L = 2;
  typedef struct {
    int id;
    logic [31:0] z;
    logic [7:0] st;
    int due;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fp_mult_arbiter_if #(.N_REQ(N)) bus();
  fp_mult_arbiter #(.N_REQ(N), .LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0, fails = 0, cyc = 0, mptr = 0;
  bit mon_en = 0, inject = 0, err_exp = 0, exp_busy = 0;
  exp_t q[$];
  exp_t e;
  logic [31:0] ra [N], rb [N];
  logic [2:0] rr [N];
  logic [31:0] exp_ma = '0, exp_mb = '0;
  logic [2:0] exp_mr = '0;
  logic [66:0] mp [L];
  logic [39:0] fo;
  logic [N-1:0] rv;
  function automatic logic [39:0] fm(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
    logic [31:0] z;
    if (a == 32'h3FC00000 && b == 32'h40000000) return {32'h40400000, 8'h00};
    if ((a == 0 && b == 32'h7F800000) || (a == 32'h7F800000 && b == 0)) return {32'h7FC00000, 8'h04};
    if (a == 32'hDEAD0040) return {a ^ b, 8'h40};
    z = (a * 3) ^ b ^ {29'd0, r};
    return {z, 2'b00, z[5:0]};
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    mp[0] <= {bus.mult_a, bus.mult_b, bus.mult_rnd};
    for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
  end
  always_comb fo = fm(mp[L-1][66:35], mp[L-1][34:3], mp[L-1][2:0]);
  assign bus.mult_z = fo[39:8];
  assign bus.mult_status = fo[7:0] | (inject ? 8'h40 : 8'h00);
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic randops();
    for (int i = 0; i < N; i++) begin
      ra[i] = $urandom;
      rb[i] = $urandom;
      rr[i] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
        ra[i] = 32'h0;
        rb[i] = 32'h7F800000;
      end
    end
  endtask
  task automatic cycle(input logic [N-1:0] v, input logic r);
    int g;
    exp_t x;
    @(negedge clk);
    #1;
    check("mult_a", bus.mult_a, exp_ma);
    check("mult_b", bus.mult_b, exp_mb);
    check("mult_rnd", bus.mult_rnd, exp_mr);
    bus.req_valid = v;
    for (int i = 0; i < N; i++) begin
      bus.req_a[32*i +: 32] = ra[i];
      bus.req_b[32*i +: 32] = rb[i];
      bus.req_rnd[3*i +: 3] = rr[i];
    end
    rst = r;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && v[(mptr + k) % N]) g = (mptr + k) % N;
    check("req_ready", bus.req_ready, g < 0 ? 0 : 1 << g);
    if (r) begin
      mptr = 0;
      exp_ma = '0;
      exp_mb = '0;
      exp_mr = '0;
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    end else if (g >= 0) begin
      x.id = g;
      {x.z, x.st} = fm(ra[g], rb[g], rr[g]);
      x.due = cyc + 2 + L;
      q.push_back(x);
      mptr = (g + 1) % N;
      exp_ma = ra[g];
      exp_mb = rb[g];
      exp_mr = rr[g];
    end else begin
      exp_ma = '0;
      exp_mb = '0;
      exp_mr = '0;
    end
  endtask
  always @(negedge clk) if (mon_en) begin
    if (rst) err_exp = 0;
    exp_busy = 0;
    foreach (q[i]) if (q[i].due - 1 - L <= cyc && cyc <= q[i].due - 1) exp_busy = 1;
    check("busy", bus.busy, exp_busy);
    if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      check("rsp_valid", bus.rsp_valid, 1 << e.id);
      if (bus.rsp_valid == N'(1 << e.id)) begin
        check("rsp_z", bus.rsp_z, e.z);
        check("rsp_status", bus.rsp_status, e.st);
      end
      if (|e.st[7:6]) err_exp = 1;
    end else check("rsp_idle", bus.rsp_valid, 0);
    check("err_sticky", bus.err_sticky, err_exp);
  end
  initial begin
    for (int i = 0; i < N; i++) begin
      ra[i] = '0;
      rb[i] = '0;
      rr[i] = '0;
    end
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_rnd = '0;
    repeat (2) @(posedge clk);
    mon_en = 1;
    cycle('0, 1'b1);
    ra[1] = 32'h3FC00000;
    rb[1] = 32'h40000000;
    rr[1] = 3'd0;
    cycle(4'b0010, 1'b0);
    repeat (6) cycle('0, 1'b0);
    cycle('0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      randops();
      cycle(4'hF, 1'b0);
    end
    repeat (6) cycle('0, 1'b0);
    cycle(4'b0010, 1'b0);
    repeat (3) cycle(4'b1001, 1'b0);
    repeat (6) cycle('0, 1'b0);
    ra[0] = 32'h0;
    rb[0] = 32'h7F800000;
    cycle(4'b0001, 1'b0);
    repeat (6) cycle('0, 1'b0);
    randops();
    cycle(4'hF, 1'b0);
    cycle(4'hF, 1'b0);
    cycle(4'hF, 1'b1);
    repeat (6) cycle('0, 1'b0);
    cycle(4'hF, 1'b0);
    repeat (6) cycle('0, 1'b0);
    inject = 1;
    repeat (4) cycle('0, 1'b0);
    inject = 0;
    ra[2] = 32'hDEAD0040;
    cycle(4'b0100, 1'b0);
    repeat (6) cycle('0, 1'b0);
    cycle('0, 1'b1);
    repeat (2) cycle('0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      randops();
      rv = N'($urandom);
      cycle(rv, $urandom_range(0, 63) == 0);
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle('0, 1'b0);
    check("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
